key_debouncer: RTL and testbench
================================

// Module: key_debouncer
// PURPOSE
//  Front-end conditioning for the 12 piano key inputs. It sits directly upstream of the
//  top-level priority encoder, which consumes keys_db in place of raw pins.
//  Each key is synchronised into clk, then integrated over a shared slow sample tick.
//  Each key also emits one-cycle press and release pulses for the LED and demo logic.
// PARAMETERS
//  NKEYS      12    number of independent key inputs (>=1)
//  TICK_DIV   1000  clk cycles per sample tick (>=1; 1 = sample every cycle)
//  STABLE_CNT 4     consecutive ticks a key must differ from keys_db before keys_db follows (>=1)
// PORTS
//  clk        in   1      system clock, all state on rising edge
//  rstn       in   1      asynchronous active-low reset
//  keys_raw   in   NKEYS  asynchronous key pins, 1 = pressed
//  keys_db    out  NKEYS  debounced key state, registered
//  key_press  out  NKEYS  1-cycle pulse, set in the first cycle a keys_db bit is 1
//  key_release out NKEYS  1-cycle pulse, set in the first cycle a keys_db bit is 0
//  any_key    out  1      registered OR of keys_db; equals |keys_db every cycle
// BEHAVIOUR
//  Reset (rstn=0, async): all outputs 0, sync flops 0, prescaler 0, all key counters 0.
//  Synchroniser: 2-FF chain per key; sync = second stage; no other logic samples keys_raw.
//  Prescaler:
//    - Counter runs 0..TICK_DIV-1 and wraps to 0.
//    - tick is a registered pulse, high for 1 cycle when the counter wraps.
//    - First tick is in cycle TICK_DIV after reset release; period is exactly TICK_DIV.
//  Per-key integrator, counter width $clog2(STABLE_CNT+1), evaluated only on tick cycles:
//    - sync == keys_db: counter <= 0.
//    - sync != keys_db and counter+1 < STABLE_CNT: counter <= counter+1.
//    - sync != keys_db and counter+1 == STABLE_CNT: keys_db <= sync, counter <= 0, flip.
//    - Non-tick cycles: counter and keys_db hold.
//  Pulses:
//    - key_press[i]   <= flip & sync[i].
//    - key_release[i] <= flip & ~sync[i].
//    - Both are registered with keys_db, so a pulse coincides with the first cycle of the new level.
//    - Press and release for one key are never high together.
//  Latency (steady change): keys_db follows within 2 + STABLE_CNT*TICK_DIV cycles.
//    It never follows earlier than 2 + (STABLE_CNT-1)*TICK_DIV + 1 cycles.
//  Glitches: any tick that sees sync == keys_db clears the counter. Bounce shorter than
//    STABLE_CNT consecutive ticks produces no keys_db change and no pulse.
//  Keys are fully independent; any number may flip on the same tick.
//  STABLE_CNT=1: keys_db follows on the first tick after sync changes.
//  Reset mid-operation: all partial counts are discarded and keys_db returns to 0.
//    No release pulses are generated by reset.
//  Counters never exceed STABLE_CNT-1 (no overflow). The prescaler wrap is seamless.
// TESTING (TICK_DIV=4, STABLE_CNT=3, NKEYS=12 unless noted)
//  1. Reset: rstn=0 with keys_raw=12'hFFF. Outputs stay 0 during reset.
//     Release rstn, hold 12'hFFF: keys_db=12'hFFF within 14 cycles.
//     key_press=12'hFFF for exactly 1 cycle, then any_key=1.
//  2. Clean press: keys_raw[0] 0->1 and held. keys_db[0] rises within 2+3*4=14 cycles.
//     key_press[0] is high 1 cycle. Later 1->0 gives key_release[0] for 1 cycle, keys_db[0]=0.
//  3. Bounce: keys_raw[5] high for 6 cycles, low for 2, high for 6, then low.
//     keys_db stays 0 and no pulses occur on any key.
//  4. Simultaneous keys: keys_raw 0 -> 12'hA05 in one cycle.
//     All four bits of keys_db rise on the same cycle. key_press=12'hA05 for 1 cycle.
//  5. Reset mid-count: keys_raw[11] held high, rstn pulsed low after 2 ticks.
//     keys_db[11] rises a full 3 ticks after reset release, not earlier.
//  6. TICK_DIV=1, STABLE_CNT=1: a 1-cycle raw pulse propagates to keys_db 3 cycles later.
//     keys_db then falls again 1 cycle after that, with matching press and release pulses.

Source files
------------

// File: rtl/key_debouncer.sv
// Key front-end: 2-FF synchroniser per key, a shared prescaler tick and a per-key
// integrator that only lets keys_db follow after STABLE_CNT consecutive differing ticks.
module key_debouncer #(
  parameter int NKEYS      = 12,
  parameter int TICK_DIV   = 1000,
  parameter int STABLE_CNT = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [NKEYS-1:0] keys_raw,
  output logic [NKEYS-1:0] keys_db,
  output logic [NKEYS-1:0] key_press,
  output logic [NKEYS-1:0] key_release,
  output logic             any_key
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(STABLE_CNT + 1);
  localparam logic [PW-1:0] PS_LAST  = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PS_ONE   = PW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CNT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [NKEYS-1:0]         sync1_r;
  logic [NKEYS-1:0]         sync_r;
  logic [PW-1:0]            ps_r;
  logic                     tick_r;
  logic [NKEYS-1:0][CW-1:0] cnt_r;
  logic [NKEYS-1:0][CW-1:0] cnt_nxt_s;
  logic [NKEYS-1:0]         db_nxt_s;
  logic [NKEYS-1:0]         flip_s;

  // Two-stage synchroniser; sync_r is the only consumer view of keys_raw.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_r <= '0;
      sync_r  <= '0;
    end else begin
      sync1_r <= keys_raw;
      sync_r  <= sync1_r;
    end
  end

  // Prescaler: tick_r is high for the one cycle following each wrap.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ps_r   <= '0;
      tick_r <= 1'b0;
    end else if (ps_r == PS_LAST) begin
      ps_r   <= '0;
      tick_r <= 1'b1;
    end else begin
      ps_r   <= ps_r + PS_ONE;
      tick_r <= 1'b0;
    end
  end

  // Integrator next state; any tick that agrees with keys_db discards the partial count.
  always_comb begin
    cnt_nxt_s = cnt_r;
    db_nxt_s  = keys_db;
    flip_s    = '0;
    for (int i = 0; i < NKEYS; i++) begin
      if (!tick_r) begin
        cnt_nxt_s[i] = cnt_r[i];
      end else if (sync_r[i] == keys_db[i]) begin
        cnt_nxt_s[i] = '0;
      end else if (cnt_r[i] == CNT_LAST) begin
        cnt_nxt_s[i] = '0;
        db_nxt_s[i]  = sync_r[i];
        flip_s[i]    = 1'b1;
      end else begin
        cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
      end
    end
  end

  // Debounced state and edge pulses are registered together so pulses mark the new level.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_r       <= '0;
      keys_db     <= '0;
      key_press   <= '0;
      key_release <= '0;
      any_key     <= 1'b0;
    end else begin
      cnt_r       <= cnt_nxt_s;
      keys_db     <= db_nxt_s;
      key_press   <= flip_s & sync_r;
      key_release <= flip_s & ~sync_r;
      any_key     <= |db_nxt_s;
    end
  end

endmodule

// File: tb/tb_key_debouncer.sv
// Directed bench: main instance TICK_DIV=4/STABLE_CNT=3, second instance TICK_DIV=1/STABLE_CNT=1.
module tb_key_debouncer;

  logic        clk = 1'b0;
  logic        rstn;
  logic [11:0] keys_raw, keys_db, key_press, key_release;
  logic        any_key;
  logic [11:0] keys_raw2, keys_db2, key_press2, key_release2;
  logic        any_key2;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;

  key_debouncer #(.NKEYS(12), .TICK_DIV(4), .STABLE_CNT(3)) dut (
    .clk(clk), .rstn(rstn), .keys_raw(keys_raw), .keys_db(keys_db),
    .key_press(key_press), .key_release(key_release), .any_key(any_key)
  );

  key_debouncer #(.NKEYS(12), .TICK_DIV(1), .STABLE_CNT(1)) dut_fast (
    .clk(clk), .rstn(rstn), .keys_raw(keys_raw2), .keys_db(keys_db2),
    .key_press(key_press2), .key_release(key_release2), .any_key(any_key2)
  );

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One rising edge, then sample/drive 1 time unit later; cyc counts edges since reset release.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto(input int e);
    while (cyc < e) step();
  endtask

  initial begin
    rstn      = 1'b0;
    keys_raw  = 12'hFFF;
    keys_raw2 = 12'h000;
    repeat (3) step();
    // Test 1: reset with all keys held
    check("rst_db",      keys_db,     12'h000);
    check("rst_press",   key_press,   12'h000);
    check("rst_release", key_release, 12'h000);
    check("rst_any",     {11'd0, any_key}, 12'h000);
    rstn = 1'b1;
    cyc  = 0;
    goto(12);
    check("t1_db_early", keys_db, 12'h000);
    goto(13);
    check("t1_db",    keys_db,   12'hFFF);
    check("t1_press", key_press, 12'hFFF);
    check("t1_any",   {11'd0, any_key}, 12'h001);
    goto(14);
    check("t1_press_end", key_press, 12'h000);
    check("t1_db_hold",   keys_db,   12'hFFF);
    keys_raw = 12'h000;
    goto(24);
    check("t1_rel_early", keys_db, 12'hFFF);
    goto(25);
    check("t1_rel_db",  keys_db,     12'h000);
    check("t1_release", key_release, 12'hFFF);
    check("t1_any_off", {11'd0, any_key}, 12'h000);
    goto(26);
    check("t1_release_end", key_release, 12'h000);
    // Test 2: clean press and release of key 0
    keys_raw = 12'h001;
    goto(36);
    check("t2_db_early", keys_db, 12'h000);
    goto(37);
    check("t2_db",    keys_db,   12'h001);
    check("t2_press", key_press, 12'h001);
    check("t2_rel0",  key_release, 12'h000);
    goto(38);
    check("t2_press_end", key_press, 12'h000);
    keys_raw = 12'h000;
    goto(48);
    check("t2_rdb_early", keys_db, 12'h001);
    goto(49);
    check("t2_rdb",     keys_db,     12'h000);
    check("t2_release", key_release, 12'h001);
    goto(50);
    check("t2_release_end", key_release, 12'h000);
    // Test 3: bounce on key 5 (6 high, 2 low, 6 high), every cycle must stay quiet
    for (int e = 51; e <= 76; e++) begin
      goto(e);
      check("t3_db",      keys_db,     12'h000);
      check("t3_press",   key_press,   12'h000);
      check("t3_release", key_release, 12'h000);
      if (e == 52 || e == 60) keys_raw = 12'h020;
      else if (e == 58 || e == 66) keys_raw = 12'h000;
    end
    // Test 4: four keys at once
    keys_raw = 12'hA05;
    goto(88);
    check("t4_db_early", keys_db, 12'h000);
    goto(89);
    check("t4_db",    keys_db,   12'hA05);
    check("t4_press", key_press, 12'hA05);
    goto(90);
    check("t4_press_end", key_press, 12'h000);
    check("t4_any",       {11'd0, any_key}, 12'h001);
    keys_raw = 12'h000;
    goto(101);
    check("t4_rel_db", keys_db,     12'h000);
    check("t4_rel",    key_release, 12'hA05);
    goto(102);
    // Test 5: key 11 held, reset after two counted ticks
    keys_raw = 12'h800;
    goto(110);
    check("t5_db_pre", keys_db, 12'h000);
    rstn = 1'b0;
    #1;
    check("t5_rst_db", keys_db, 12'h000);
    step();
    step();
    rstn = 1'b1;
    cyc  = 0;
    goto(12);
    check("t5_db_early", keys_db, 12'h000);
    goto(13);
    check("t5_db",    keys_db,   12'h800);
    check("t5_press", key_press, 12'h800);
    goto(14);
    check("t5_any", {11'd0, any_key}, 12'h001);
    // Reset with keys_db set: clears it without any release pulse
    rstn     = 1'b0;
    keys_raw = 12'h000;
    #1;
    check("t5_rst2_db",  keys_db,     12'h000);
    check("t5_rst2_rel", key_release, 12'h000);
    check("t5_rst2_any", {11'd0, any_key}, 12'h000);
    step();
    rstn = 1'b1;
    cyc  = 0;
    goto(2);
    check("t5_post_rel", key_release, 12'h000);
    // Test 6: fast instance, 1-cycle raw pulse
    goto(3);
    keys_raw2 = 12'h001;
    goto(4);
    keys_raw2 = 12'h000;
    goto(5);
    check("t6_db_early", keys_db2, 12'h000);
    goto(6);
    check("t6_db",    keys_db2,   12'h001);
    check("t6_press", key_press2, 12'h001);
    check("t6_any",   {11'd0, any_key2}, 12'h001);
    goto(7);
    check("t6_db_fall",  keys_db2,     12'h000);
    check("t6_release",  key_release2, 12'h001);
    check("t6_press_end", key_press2,  12'h000);
    goto(8);
    check("t6_release_end", key_release2, 12'h000);
    check("t6_main_db",     keys_db,      12'h000);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
